// File: rtl/fetch_pkg.sv
// Shared types for the fetch sequencing controller: address type, FSM states,
// request vector and the fixed request priority.
package fetch_pkg;

  localparam int unsigned ADDR_W = 8;

  typedef logic [ADDR_W-1:0] addr_t;

  localparam addr_t IRQ_VECTOR_DEFAULT = 8'hF0;

  typedef enum logic [2:0] {
    IDLE,
    LAUNCH,
    RUN,
    REDIRECT,
    HALTED
  } fetch_state_e;

  // One bit per sequencing request, already qualified by state.
  typedef struct packed {
    logic go;
    logic halt;
    logic irq;
    logic ret;
    logic br;
  } fetch_req_t;

  // Keep only the highest-priority request: go > halt > irq > ret > br.
  function automatic fetch_req_t req_priority(input fetch_req_t raw);
    fetch_req_t r;
    r = '0;
    if (raw.go)        r.go   = 1'b1;
    else if (raw.halt) r.halt = 1'b1;
    else if (raw.irq)  r.irq  = 1'b1;
    else if (raw.ret)  r.ret  = 1'b1;
    else if (raw.br)   r.br   = 1'b1;
    return r;
  endfunction

endpackage

// File: rtl/fetch_target.sv
// Next fetch load address for the winning request (combinational).
module fetch_target
  import fetch_pkg::*;
#(
  parameter addr_t IRQ_VECTOR = IRQ_VECTOR_DEFAULT
) (
  input  fetch_req_t req,
  input  addr_t      pc,
  input  addr_t      br_offset,
  input  addr_t      epc,
  input  addr_t      boot_addr,
  output addr_t      next_address_c
);

  // Target mux; 8-bit adds wrap mod 256, so sign extension of the offset is implicit.
  always_comb begin
    next_address_c = boot_addr;
    if (req.go)        next_address_c = boot_addr;
    else if (req.halt) next_address_c = addr_t'(pc + addr_t'(1));
    else if (req.irq)  next_address_c = IRQ_VECTOR;
    else if (req.ret)  next_address_c = epc;
    else if (req.br)   next_address_c = addr_t'(pc + br_offset);
  end

endmodule

// File: rtl/fetch_ctrl.sv
// Sequencing controller for the fetch PC unit: turns launch/halt/branch/
// interrupt/return requests into absolute start loads, tags live PCs and
// counts issued instructions.
// Optional feature macro: FETCH_CTRL_IRQ_EN (interrupt entry/return, EPC).
module fetch_ctrl
  import fetch_pkg::*;
#(
  parameter addr_t       IRQ_VECTOR = IRQ_VECTOR_DEFAULT,
  parameter int unsigned CNT_W      = 16
) (
  input  logic              clk,
  input  logic              reset_i,
  input  logic              go_i,
  input  logic [ADDR_W-1:0] boot_addr_i,
  input  logic [ADDR_W-1:0] pc_i,
  input  logic              br_req_i,
  input  logic [ADDR_W-1:0] br_offset_i,
  input  logic              halt_i,
  input  logic              irq_i,
  input  logic              ret_i,
  output logic              start_o,
  output logic [ADDR_W-1:0] start_address_o,
  output logic              valid_o,
  output logic              halted_o,
  output logic              in_irq_o,
  output logic [ADDR_W-1:0] epc_o,
  output logic [CNT_W-1:0]  instr_count_o
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  fetch_state_e state;
  fetch_req_t   raw_req;
  fetch_req_t   req;
  addr_t        next_address_c;
  addr_t        epc;
  logic         live;
  logic         irq_ok;
  logic         ret_ok;

  // Instruction-bound requests only act on a live (non-squashed) PC.
  assign live = (state == RUN) && valid_o;

`ifdef FETCH_CTRL_IRQ_EN
  logic  in_irq_q;
  addr_t epc_q;

  assign irq_ok   = irq_i & ~in_irq_q;
  assign ret_ok   = ret_i & in_irq_q;
  assign epc      = epc_q;
  assign in_irq_o = in_irq_q;
  assign epc_o    = epc_q;

  // Interrupt-active flag and resume address (no nesting).
  always_ff @(posedge clk) begin
    if (reset_i) begin
      in_irq_q <= 1'b0;
      epc_q    <= '0;
    end else if (req.go) begin
      in_irq_q <= 1'b0;
    end else if (req.irq) begin
      in_irq_q <= 1'b1;
      epc_q    <= (state == HALTED) ? start_address_o : addr_t'(pc_i + addr_t'(1));
    end else if (req.ret) begin
      in_irq_q <= 1'b0;
    end
  end
`else
  logic unused_irq;

  assign unused_irq = irq_i ^ ret_i;
  assign irq_ok     = 1'b0;
  assign ret_ok     = 1'b0;
  assign epc        = '0;
  assign in_irq_o   = 1'b0;
  assign epc_o      = '0;
`endif

  // Qualify raw inputs by state, then keep the single winning request.
  always_comb begin
    raw_req      = '0;
    raw_req.go   = go_i;
    raw_req.halt = halt_i & live;
    raw_req.irq  = irq_ok & (live | (state == HALTED));
    raw_req.ret  = ret_ok & live;
    raw_req.br   = br_req_i & live;
  end

  assign req = req_priority(raw_req);

  fetch_target #(
    .IRQ_VECTOR (IRQ_VECTOR)
  ) u_target (
    .req            (req),
    .pc             (pc_i),
    .br_offset      (br_offset_i),
    .epc            (epc),
    .boot_addr      (boot_addr_i),
    .next_address_c (next_address_c)
  );

  // Saturating count of live cycles; relaunch clears it.
  always_ff @(posedge clk) begin
    if (reset_i) begin
      instr_count_o <= '0;
    end else if (req.go) begin
      instr_count_o <= '0;
    end else if (valid_o && (instr_count_o != CNT_MAX)) begin
      instr_count_o <= instr_count_o + CNT_W'(1);
    end
  end

  // Sequencing FSM with registered fetch-load and status outputs.
  always_ff @(posedge clk) begin
    if (reset_i) begin
      state           <= IDLE;
      start_o         <= 1'b1;
      start_address_o <= '0;
      valid_o         <= 1'b0;
      halted_o        <= 1'b0;
    end else if (req.go) begin
      state           <= LAUNCH;
      start_o         <= 1'b1;
      start_address_o <= next_address_c;
      valid_o         <= 1'b0;
      halted_o        <= 1'b0;
    end else if (req.halt) begin
      state           <= HALTED;
      start_o         <= 1'b1;
      start_address_o <= next_address_c;
      valid_o         <= 1'b0;
      halted_o        <= 1'b1;
    end else if (req.irq || req.ret || req.br) begin
      state           <= REDIRECT;
      start_o         <= 1'b1;
      start_address_o <= next_address_c;
      valid_o         <= 1'b0;
      halted_o        <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          start_o  <= 1'b1;
          valid_o  <= 1'b0;
          halted_o <= 1'b0;
        end
        LAUNCH, REDIRECT, RUN: begin
          state    <= RUN;
          start_o  <= 1'b0;
          valid_o  <= 1'b1;
          halted_o <= 1'b0;
        end
        HALTED: begin
          start_o  <= 1'b1;
          valid_o  <= 1'b0;
          halted_o <= 1'b1;
        end
        default: begin
          state    <= IDLE;
          start_o  <= 1'b1;
          valid_o  <= 1'b0;
          halted_o <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/fetch_ctrl.md
# fetch_ctrl

Sequencing controller for the 8-bit `fetch` PC unit. It converts launch, halt, relative-branch, interrupt and return requests into the fetch unit's absolute `start_i`/`start_address_i` load, so the fetch unit's own `branch_i`/`branchloc_i` are tied 0 at the top level. It also tags each fetched PC as valid or squashed and counts issued instructions. The controller sits between fetch and the decode/execute stages.

## Interface
- `IRQ_VECTOR`, default 8'hF0: absolute interrupt handler address.
- `CNT_W`, default 16: instruction counter width.

- `clk` in 1: clock, rising edge.
- `reset_i` in 1: synchronous, active-high reset.
- `go_i` in 1: launch or relaunch the program at `boot_addr_i`.
- `boot_addr_i` in 8: launch address.
- `pc_i` in 8: current `pc` from fetch.
- `br_req_i` in 1: taken relative branch for the instruction at `pc_i`.
- `br_offset_i` in 8: signed two's-complement branch offset.
- `halt_i` in 1: halt instruction at `pc_i`.
- `irq_i` in 1: level-sensitive interrupt request.
- `ret_i` in 1: return-from-interrupt instruction at `pc_i`.
- `start_o` out 1: drives fetch `start_i`.
- `start_address_o` out 8: drives fetch `start_address_i`.
- `valid_o` out 1: `pc_i` holds a live instruction this cycle.
- `halted_o` out 1: the controller is in HALTED.
- `in_irq_o` out 1: an interrupt handler is active.
- `epc_o` out 8: saved resume address.
- `instr_count_o` out CNT_W: count of valid cycles.

## Operation
- All outputs are registered.
- Reset values: state IDLE, `start_o`=1, `start_address_o`=0, `valid_o`=0, `halted_o`=0, `in_irq_o`=0, `epc_o`=0, `instr_count_o`=0.
- Address arithmetic is 8-bit and wraps mod 256.
- Branch target = `pc_i` + sign-extended `br_offset_i`.
- States:
  - IDLE: holds pc at `start_address_o`. On `go_i`, moves to LAUNCH.
  - LAUNCH: `start_o`=1 with `boot_addr_i`. Moves to RUN.
  - RUN: `start_o`=0, `valid_o`=1.
  - REDIRECT: `start_o`=1 with the target, `valid_o`=0. Moves to RUN.
  - HALTED: `start_o`=1 with the held address, `halted_o`=1.
- Request priority in RUN, one action per cycle: `go_i` > `halt_i` > `irq_i` > `ret_i` > `br_req_i`.
- `go_i` in any state:
  - moves to LAUNCH;
  - clears `instr_count_o`, `in_irq_o` and `halted_o`.
- `halt_i`: moves to HALTED and holds pc at `pc_i`+1.
- `irq_i`, only when `in_irq_o`=0:
  - `epc_o` ← `pc_i`+1 from RUN, or the held address from HALTED;
  - `in_irq_o` ← 1;
  - redirect to `IRQ_VECTOR`.
  - An IRQ asserted while `in_irq_o`=1 or during LAUNCH/REDIRECT is not nested; it is serviced later if the level persists.
- `ret_i` with `in_irq_o`=1: redirect to `epc_o` and clear `in_irq_o`. With `in_irq_o`=0, `ret_i` is ignored.
- `br_req_i`: redirect to the branch target.
- `halt_i`, `ret_i` and `br_req_i` are ignored whenever `valid_o`=0, i.e. the shadow-slot PC is squashed.
- `instr_count_o` increments on every `valid_o`=1 cycle and saturates at all-ones.

## Timing
- A request sampled at edge E sets `start_o` for the following cycle. Fetch loads the new pc at edge E+1.
- `valid_o`=1 with the new pc from edge E+1.
- The redirect penalty is exactly one squashed cycle, for `pc_i` = P+1.
- Launch latency: `go_i` at edge E gives the first valid pc = `boot_addr_i` after edge E+1.
- A reset asserted at any point, including mid-redirect, reaches IDLE on the next edge. Pending requests are dropped.

## Configuration
- `FETCH_CTRL_IRQ_EN` defined: IRQ/return logic, `epc_o` and `in_irq_o` are present as described.
- `FETCH_CTRL_IRQ_EN` undefined:
  - `irq_i` and `ret_i` are ignored;
  - `epc_o` and `in_irq_o` are tied 0;
  - no EPC register is built.
- All port lists are identical in both builds.

## Structure
- `fetch_pkg` holds:
  - the `addr_t` (8-bit) typedef;
  - the `fetch_state_e` enum (IDLE, LAUNCH, RUN, REDIRECT, HALTED);
  - the default IRQ vector constant.
- One sub-module, `fetch_target`: combinational target mux and adder. Its inputs are the request vector, `pc_i`, `br_offset_i`, `epc_o` and `boot_addr_i`. It outputs the next `start_address_o`.

## Test plan
- Reset then `go_i` with `boot_addr_i`=8'h10: pc = 8'h10, 8'h11, 8'h12 with `valid_o`=1; `instr_count_o`=3 after three valid cycles.
- Branch with `pc_i`=8'h12, `br_offset_i`=8'hFC: one squashed cycle, then pc=8'h0E valid. Repeat with `pc_i`=8'hFE, offset 8'h04: target wraps to 8'h02.
- Halt at `pc_i`=8'h20: `halted_o`=1 and pc held at 8'h21 for 10 cycles with `valid_o`=0. A later `go_i` relaunches at `boot_addr_i`.
- `halt_i`, `irq_i` and `br_req_i` together at `pc_i`=8'h30: halt wins. `irq_i` still high then redirects to 8'hF0, `epc_o`=8'h31, `in_irq_o`=1. `ret_i` resumes at 8'h31.
- With `FETCH_CTRL_IRQ_EN` undefined, `irq_i`=1 for 20 cycles: pc keeps incrementing and `epc_o`=0.
- Reset asserted during REDIRECT: IDLE next edge with all outputs at reset values.
